// File: rtl/levinson_order_sequencer_pkg.sv
// Shared state encoding, fault codes and float constants
// for the Levinson-Durbin order sequencer.
package levinson_order_sequencer_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_REQ,
      S_STEP_RST,
      S_STEP_RUN,
      S_EMIT,
      S_FILL,
      S_FINISH
   } seq_state_t;

   typedef logic [1:0] fault_t;

   localparam fault_t FAULT_OK      = 2'd0;
   localparam fault_t FAULT_DEGEN   = 2'd1;
   localparam fault_t FAULT_TIMEOUT = 2'd2;

   localparam logic [31:0] FP_ZERO_MASK = 32'h7FFFFFFF;
   localparam logic [31:0] FP_ONE       = 32'h3F800000;

   // Both +0 and -0 count as a degenerate error.
   function automatic logic fp_is_zero(input logic [31:0] f);
      return (f & FP_ZERO_MASK) == 32'd0;
   endfunction

endpackage

// File: rtl/levinson_order_sequencer_step_watchdog.sv
// Loadable down-counter that flags when a step-unit run
// has used up its cycle allowance.
module levinson_order_sequencer_step_watchdog #(
   parameter int TIMEOUT = 64
) (
   input  logic iClock,
   input  logic iReset,
   input  logic load,
   input  logic tick,
   output logic expired
);

   localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [CW-1:0] LOAD_VAL = CW'(TIMEOUT - 1);

   logic [CW-1:0] count;

   always_ff @(posedge iClock) begin
      if (iReset)
         count <= '0;
      else if (load)
         count <= LOAD_VAL;
      else if (tick && !expired)
         count <= count - 1'b1;
   end

   assign expired = (count == '0);

endmodule

// File: rtl/levinson_order_sequencer.sv
// Walks the LPC order index, fetching alpha and running the
// K/error step unit once per order, streaming K values out.
module levinson_order_sequencer
   import levinson_order_sequencer_pkg::*;
#(
   parameter int MAX_ORDER    = 32,
   parameter int ORDER_W      = 6,
   parameter int STEP_TIMEOUT = 64
) (
   input  logic               iClock,
   input  logic               iReset,
   input  logic               iStart,
   input  logic [ORDER_W-1:0] iOrder,
   input  logic [31:0]        iError0,
   output logic               oAlphaReq,
   output logic [ORDER_W-1:0] oAlphaIdx,
   input  logic               iAlphaValid,
   input  logic [31:0]        iAlpha,
   output logic               oStepReset,
   output logic               oStepEnable,
   output logic [31:0]        oStepAlpha,
   output logic [31:0]        oStepError,
   input  logic               iStepDone,
   input  logic [31:0]        iStepK,
   input  logic [31:0]        iStepError,
   output logic               oKValid,
   output logic [ORDER_W-1:0] oKIdx,
   output logic [31:0]        oK,
   output logic [31:0]        oError,
   output logic               oBusy,
   output logic               oDone,
   output logic [1:0]         oFault
);

   localparam logic [ORDER_W-1:0] MAX_O   = ORDER_W'(MAX_ORDER);
   localparam logic [ORDER_W-1:0] IDX_ONE = ORDER_W'(1);

   seq_state_t state, state_nx;

   logic [ORDER_W-1:0] order, m, order_in;
   logic [31:0] err, alpha, k_lat, err_lat;
   fault_t fault;
   logic last, step_rst;
   logic wd_load, wd_tick, wd_expired;

   assign order_in = (iOrder > MAX_O) ? MAX_O : iOrder;
   assign last     = (m == order - IDX_ONE);

   levinson_order_sequencer_step_watchdog #(
      .TIMEOUT (STEP_TIMEOUT)
   ) u_watchdog (
      .iClock  (iClock),
      .iReset  (iReset),
      .load    (wd_load),
      .tick    (wd_tick),
      .expired (wd_expired)
   );

   always_ff @(posedge iClock) begin
      if (iReset)
         state <= S_IDLE;
      else
         state <= state_nx;
   end

   always_comb begin
      state_nx    = state;
      oAlphaReq   = 1'b0;
      oAlphaIdx   = '0;
      step_rst    = 1'b0;
      oStepEnable = 1'b0;
      oKValid     = 1'b0;
      oKIdx       = '0;
      oK          = '0;
      oDone       = 1'b0;
      oError      = '0;
      oFault      = FAULT_OK;
      wd_load     = 1'b0;
      wd_tick     = 1'b0;
      unique case (state)
         S_IDLE: begin
            if (iStart) begin
               if (order_in == '0)
                  state_nx = S_FINISH;
               else if (fp_is_zero(iError0))
                  state_nx = S_FILL;
               else
                  state_nx = S_REQ;
            end
         end
         S_REQ: begin
            oAlphaReq = 1'b1;
            oAlphaIdx = m;
            if (iAlphaValid)
               state_nx = S_STEP_RST;
         end
         S_STEP_RST: begin
            step_rst = 1'b1;
            wd_load  = 1'b1;
            state_nx = S_STEP_RUN;
         end
         S_STEP_RUN: begin
            oStepEnable = 1'b1;
            wd_tick     = 1'b1;
            // A done arriving on the last allowed cycle still counts.
            if (iStepDone)
               state_nx = S_EMIT;
            else if (wd_expired)
               state_nx = S_FILL;
         end
         S_EMIT: begin
            oKValid = 1'b1;
            oKIdx   = m;
            oK      = k_lat;
            if (last)
               state_nx = S_FINISH;
            else if (fp_is_zero(err_lat))
               state_nx = S_FILL;
            else
               state_nx = S_REQ;
         end
         S_FILL: begin
            oKValid = 1'b1;
            oKIdx   = m;
            if (last)
               state_nx = S_FINISH;
         end
         S_FINISH: begin
            oDone    = 1'b1;
            oError   = err;
            oFault   = fault;
            state_nx = S_IDLE;
         end
         default: state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge iClock) begin
      if (iReset) begin
         order   <= '0;
         m       <= '0;
         err     <= '0;
         alpha   <= '0;
         k_lat   <= '0;
         err_lat <= '0;
         fault   <= FAULT_OK;
      end else begin
         unique case (state)
            S_IDLE: begin
               if (iStart) begin
                  order <= order_in;
                  err   <= iError0;
                  m     <= '0;
                  if (order_in != '0 && fp_is_zero(iError0))
                     fault <= FAULT_DEGEN;
                  else
                     fault <= FAULT_OK;
               end
            end
            S_REQ: begin
               if (iAlphaValid)
                  alpha <= iAlpha;
            end
            S_STEP_RUN: begin
               if (iStepDone) begin
                  k_lat   <= iStepK;
                  err_lat <= iStepError;
               end else if (wd_expired) begin
                  fault <= FAULT_TIMEOUT;
               end
            end
            S_EMIT: begin
               err <= err_lat;
               // A degenerate error starts the fill at the next index.
               if (!last) begin
                  m <= m + IDX_ONE;
                  if (fp_is_zero(err_lat))
                     fault <= FAULT_DEGEN;
               end
            end
            S_FILL: begin
               if (!last)
                  m <= m + IDX_ONE;
            end
            default: ;
         endcase
      end
   end

   assign oStepReset = iReset | step_rst;
   assign oBusy      = (state != S_IDLE);
   assign oStepAlpha = alpha;
   assign oStepError = err;

endmodule

// File: tb/tb_levinson_order_sequencer.sv
// Randomised frame-level bench with a step-unit model and a
// recursion reference model for the order sequencer.
module tb_levinson_order_sequencer;
   import levinson_order_sequencer_pkg::*;

   localparam int OW  = 6;
   localparam int LAT = 31;

   logic iClock = 1'b0;
   logic iReset = 1'b1;
   logic iStart = 1'b0;
   logic [OW-1:0] iOrder = '0;
   logic [31:0] iError0 = '0;
   logic iAlphaValid = 1'b0;
   logic [31:0] iAlpha = '0;
   logic iStepDone = 1'b0;
   logic [31:0] iStepK = '0;
   logic [31:0] iStepError = '0;
   logic oAlphaReq, oStepReset, oStepEnable;
   logic oKValid, oBusy, oDone;
   logic [OW-1:0] oAlphaIdx, oKIdx;
   logic [31:0] oStepAlpha, oStepError, oK, oError;
   logic [1:0] oFault;

   levinson_order_sequencer dut (
      .iClock      (iClock),
      .iReset      (iReset),
      .iStart      (iStart),
      .iOrder      (iOrder),
      .iError0     (iError0),
      .oAlphaReq   (oAlphaReq),
      .oAlphaIdx   (oAlphaIdx),
      .iAlphaValid (iAlphaValid),
      .iAlpha      (iAlpha),
      .oStepReset  (oStepReset),
      .oStepEnable (oStepEnable),
      .oStepAlpha  (oStepAlpha),
      .oStepError  (oStepError),
      .iStepDone   (iStepDone),
      .iStepK      (iStepK),
      .iStepError  (iStepError),
      .oKValid     (oKValid),
      .oKIdx       (oKIdx),
      .oK          (oK),
      .oError      (oError),
      .oBusy       (oBusy),
      .oDone       (oDone),
      .oFault      (oFault)
   );

   always #5 iClock = ~iClock;

   int checks = 0;
   int errors = 0;

   logic [31:0] alpha_lit [64];
   logic [31:0] alpha_plan [64];
   bit use_e [64];
   int delay_plan [64];
   int hang_at = -1;

   logic [OW-1:0] exp_idx [$];
   logic [31:0] exp_k [$];
   logic [OW-1:0] got_idx [$];
   logic [31:0] got_k [$];
   logic [31:0] exp_err, got_err;
   logic [1:0] exp_fault, got_fault;
   int exp_reqs, req_seen, en_cnt, run_no;
   bit frame_active = 0;
   bit done_seen = 0;

   logic [31:0] e_tab [6] = '{32'h3F800000, 32'h40000000,
      32'h3F400000, 32'h40400000, 32'h80000000, 32'h00000000};
   logic [31:0] a_tab [5] = '{32'h3F000000, 32'hBE800000,
      32'h00000000, 32'h3E000000, 32'h3F400000};

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h want %h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] to_f32(input real r);
      logic [63:0] d;
      int ex;
      logic [24:0] mm;
      d = $realtobits(r);
      ex = int'(d[62:52]) - 896;
      if (ex <= 0) return {d[63], 31'b0};
      if (ex >= 255) return {d[63], 8'hFF, 23'b0};
      mm = {2'b01, d[51:29]};
      if (d[28] && ((|d[27:0]) || mm[0])) mm = mm + 25'd1;
      if (mm[24]) begin
         mm = mm >> 1;
         ex = ex + 1;
      end
      if (ex >= 255) return {d[63], 8'hFF, 23'b0};
      return {d[63], ex[7:0], mm[22:0]};
   endfunction

   function automatic real to_real(input logic [31:0] f);
      logic [10:0] de;
      if (f[30:23] == 8'd0) return 0.0;
      de = {3'b000, f[30:23]} + 11'd896;
      return $bitstoreal({f[31], de, f[22:0], 29'b0});
   endfunction

   // K = -a/E, E' = E - E*K^2, with K rounded to single first.
   task automatic step_calc(input logic [31:0] a, input logic [31:0] e,
                            output logic [31:0] k, output logic [31:0] en);
      real ra, re, rk;
      ra = to_real(a);
      re = to_real(e);
      rk = (re == 0.0) ? 0.0 : (0.0 - ra) / re;
      k = to_f32(rk);
      rk = to_real(k);
      en = to_f32(re - re * rk * rk);
   endtask

   always @(negedge iClock) begin
      if (!iReset) begin
         if (oStepEnable) en_cnt++;
         if (oKValid) begin
            got_k.push_back(oK);
            got_idx.push_back(oKIdx);
            if (exp_k.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL k_extra idx %0d got %h want none", oKIdx, oK);
            end else begin
               chk("k_idx", 32'(oKIdx), 32'(exp_idx.pop_front()));
               chk("k_val", oK, exp_k.pop_front());
            end
         end
         if (oDone) begin
            got_err = oError;
            got_fault = oFault;
            if (!frame_active) begin
               checks++;
               errors++;
               $display("FAIL done_stray got oDone=1 want 0");
            end else begin
               chk("error", oError, exp_err);
               chk("fault", 32'(oFault), 32'(exp_fault));
               chk("k_left", 32'(exp_k.size()), 32'd0);
               chk("alpha_reqs", req_seen, exp_reqs);
               frame_active = 0;
               done_seen = 1;
            end
         end
      end
   end

   bit in_req = 0;
   bit delivered = 0;
   int wait_cnt = 0;

   always @(negedge iClock) begin
      if (oAlphaReq && !iReset) begin
         if (!in_req) begin
            in_req = 1;
            delivered = 0;
            chk("alpha_idx", 32'(oAlphaIdx), req_seen);
            wait_cnt = delay_plan[oAlphaIdx];
            req_seen++;
         end
         if (wait_cnt == 0) begin
            iAlphaValid = 1'b1;
            iAlpha = alpha_plan[oAlphaIdx];
            delivered = 1;
         end else begin
            iAlphaValid = 1'b0;
            iAlpha = $urandom;
            wait_cnt--;
         end
      end else begin
         if (in_req && !iReset) chk("alpha_req_held", 32'(delivered), 32'd1);
         in_req = 0;
         iAlphaValid = ($urandom_range(7) == 0);
         iAlpha = $urandom;
      end
   end

   bit hanging = 0;
   int scnt = 0;
   logic [31:0] sk, se;

   always @(negedge iClock) begin
      if (oStepReset) begin
         iStepDone = 1'b0;
         scnt = 0;
         iStepK = $urandom;
         iStepError = $urandom;
         hanging = (run_no == hang_at);
         if (!iReset) run_no++;
      end else if (oStepEnable && !iStepDone && !hanging) begin
         scnt++;
         if (scnt == LAT) begin
            step_calc(oStepAlpha, oStepError, sk, se);
            iStepK = sk;
            iStepError = se;
            iStepDone = 1'b1;
         end
      end
   end

   task automatic clear_plan();
      for (int i = 0; i < 64; i++) begin
         alpha_lit[i] = '0;
         alpha_plan[i] = '0;
         use_e[i] = 0;
         delay_plan[i] = 0;
      end
      hang_at = -1;
   endtask

   task automatic push_zeros(input int from, input int to);
      for (int j = from; j < to; j++) begin
         exp_idx.push_back(OW'(j));
         exp_k.push_back(32'd0);
      end
   endtask

   task automatic start_frame(input logic [OW-1:0] ord_req,
                              input logic [31:0] e0);
      int ord;
      logic [31:0] e, k, en;
      logic [1:0] f;
      exp_k.delete();
      exp_idx.delete();
      got_k.delete();
      got_idx.delete();
      req_seen = 0;
      en_cnt = 0;
      run_no = 0;
      exp_reqs = 0;
      done_seen = 0;
      ord = (ord_req > 32) ? 32 : int'(ord_req);
      e = e0;
      f = FAULT_OK;
      if (ord != 0 && fp_is_zero(e0)) begin
         f = FAULT_DEGEN;
         push_zeros(0, ord);
      end else begin
         for (int i = 0; i < ord; i++) begin
            exp_reqs++;
            alpha_plan[i] = use_e[i] ? e : alpha_lit[i];
            if (i == hang_at) begin
               f = FAULT_TIMEOUT;
               push_zeros(i, ord);
               break;
            end
            step_calc(alpha_plan[i], e, k, en);
            exp_idx.push_back(OW'(i));
            exp_k.push_back(k);
            e = en;
            if (i == ord - 1) break;
            if (fp_is_zero(e)) begin
               f = FAULT_DEGEN;
               push_zeros(i + 1, ord);
               break;
            end
         end
      end
      exp_err = e;
      exp_fault = f;
      frame_active = 1;
      iOrder = ord_req;
      iError0 = e0;
      iStart = 1'b1;
      @(negedge iClock);
      iStart = 1'b0;
      chk("busy_after_start", 32'(oBusy), 32'd1);
   endtask

   task automatic wait_done(input int budget, input bit noise,
                            input bit fin_start);
      bit seen;
      seen = 0;
      for (int c = 0; c < budget && !seen; c++) begin
         @(negedge iClock);
         iStart = noise && ($urandom_range(3) == 0);
         iOrder = OW'($urandom);
         iError0 = $urandom;
         if (oDone) begin
            seen = 1;
            iStart = fin_start;
         end
      end
      if (!seen) begin
         checks++;
         errors++;
         $display("FAIL done_timeout got no oDone want oDone in %0d", budget);
         iStart = 1'b0;
         iReset = 1'b1;
         repeat (2) @(negedge iClock);
         iReset = 1'b0;
         frame_active = 0;
      end else begin
         @(negedge iClock);
         iStart = 1'b0;
         chk("idle_after_done", 32'(oBusy), 32'd0);
         chk("done_seen", 32'(done_seen), 32'd1);
      end
   endtask

   initial begin
      #900000;
      $display("FAIL global_timeout got running want finished");
      $fatal(1);
   end

   initial begin
      bit seen;
      int ord;
      clear_plan();
      repeat (3) @(negedge iClock);
      chk("rst_step_reset", 32'(oStepReset), 32'd1);
      chk("rst_busy", 32'(oBusy), 32'd0);
      chk("rst_alpha_req", 32'(oAlphaReq), 32'd0);
      chk("rst_kvalid", 32'(oKValid), 32'd0);
      chk("rst_done", 32'(oDone), 32'd0);
      chk("rst_enable", 32'(oStepEnable), 32'd0);
      chk("rst_step_alpha", oStepAlpha, 32'd0);
      iReset = 1'b0;
      @(negedge iClock);
      chk("post_rst_step_reset", 32'(oStepReset), 32'd0);
      chk("post_rst_fault", 32'(oFault), 32'd0);

      clear_plan();
      alpha_lit[0] = 32'h3F000000;
      start_frame(1, FP_ONE);
      wait_done(200, 0, 0);
      chk("t1_count", got_k.size(), 1);
      chk("t1_k0", got_k[0], 32'hBF000000);
      chk("t1_err", got_err, 32'h3F400000);
      chk("t1_fault", 32'(got_fault), 32'd0);

      clear_plan();
      alpha_lit[0] = 32'h3F000000;
      delay_plan[1] = 5;
      delay_plan[2] = 17;
      start_frame(3, FP_ONE);
      wait_done(400, 0, 1);
      chk("t2_count", got_k.size(), 3);
      chk("t2_k0", got_k[0], 32'hBF000000);
      chk("t2_k1", got_k[1], 32'h00000000);
      chk("t2_k2", got_k[2], 32'h00000000);
      chk("t2_idx2", 32'(got_idx[2]), 32'd2);
      chk("t2_err", got_err, 32'h3F400000);

      clear_plan();
      start_frame(4, 32'h00000000);
      wait_done(100, 0, 0);
      chk("t3_count", got_k.size(), 4);
      for (int i = 0; i < 4; i++) chk("t3_k", got_k[i], 32'd0);
      chk("t3_reqs", req_seen, 0);
      chk("t3_fault", 32'(got_fault), 32'd1);

      clear_plan();
      alpha_lit[0] = 32'h3F000000;
      hang_at = 0;
      start_frame(2, FP_ONE);
      wait_done(400, 0, 0);
      chk("t4_run_cycles", en_cnt, 64);
      chk("t4_count", got_k.size(), 2);
      chk("t4_idx0", 32'(got_idx[0]), 32'd0);
      chk("t4_idx1", 32'(got_idx[1]), 32'd1);
      chk("t4_k0", got_k[0], 32'd0);
      chk("t4_k1", got_k[1], 32'd0);
      chk("t4_fault", 32'(got_fault), 32'd2);
      chk("t4_err", got_err, FP_ONE);

      clear_plan();
      alpha_lit[0] = 32'h3F000000;
      start_frame(2, FP_ONE);
      seen = 0;
      for (int c = 0; c < 100 && !seen; c++) begin
         @(negedge iClock);
         seen = oStepEnable;
      end
      chk("t5_reached_run", 32'(seen), 32'd1);
      repeat (5) @(negedge iClock);
      frame_active = 0;
      iReset = 1'b1;
      @(negedge iClock);
      chk("t5_step_reset", 32'(oStepReset), 32'd1);
      @(negedge iClock);
      iReset = 1'b0;
      repeat (60) @(negedge iClock);
      chk("t5_idle", 32'(oBusy), 32'd0);
      clear_plan();
      alpha_lit[0] = 32'h3F000000;
      start_frame(1, FP_ONE);
      wait_done(200, 1, 1);
      chk("t5_count", got_k.size(), 1);
      chk("t5_k0", got_k[0], 32'hBF000000);
      chk("t5_err", got_err, 32'h3F400000);

      clear_plan();
      for (int i = 0; i < 64; i++) begin
         alpha_lit[i] = a_tab[$urandom_range(4)];
         delay_plan[i] = $urandom_range(2);
      end
      start_frame(40, FP_ONE);
      wait_done(3000, 1, 0);
      chk("t6_count", got_k.size(), 32);
      chk("t6_last_idx", 32'(got_idx[31]), 32'd31);

      for (int f = 0; f < 16; f++) begin
         clear_plan();
         ord = $urandom_range(40);
         for (int i = 0; i < 64; i++) begin
            alpha_lit[i] = a_tab[$urandom_range(4)];
            use_e[i] = ($urandom_range(15) == 0);
            delay_plan[i] = $urandom_range(3);
         end
         if ($urandom_range(4) == 0) hang_at = $urandom_range(ord);
         start_frame(OW'(ord), e_tab[$urandom_range(5)]);
         wait_done(80 * (ord + 1) + 100, 1, $urandom_range(1) == 1);
         repeat ($urandom_range(3)) @(negedge iClock);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/levinson_order_sequencer.md
Name: levinson_order_sequencer

Overview:
Sequences the Levinson-Durbin recursion for one LPC analysis frame. The block walks the order index m from 0 to order-1. For each order it fetches alpha_m from the upstream dot-product unit through a valid/ready-style handshake, then runs the single-step K/error unit (reset pulse, then hold enable until done). It captures K_{m+1} and E_{m+1}, streams each K out, and feeds E_{m+1} back as the next step's error. It sits between the autocorrelation/alpha datapath and the coefficient-update stage of the hardware encoder.

Parameters:
MAX_ORDER, 32, largest supported LPC order; iOrder above this is clamped
ORDER_W, 6, width of order/index fields (clog2(MAX_ORDER)+1)
STEP_TIMEOUT, 64, cycles allowed per step-unit run before an abort

Ports:
iClock  in  1  clock
iReset  in  1  synchronous, active-high reset
iStart  in  1  single-cycle pulse; starts a frame when idle, ignored otherwise
iOrder  in  ORDER_W  requested LPC order, sampled on iStart
iError0  in  32  E_0 = R(0), IEEE-754 single, sampled on iStart
oAlphaReq  out  1  request for alpha_m; held until iAlphaValid
oAlphaIdx  out  ORDER_W  m for the current request
iAlphaValid  in  1  alpha_m is present on iAlpha this cycle
iAlpha  in  32  alpha_m, float
oStepReset  out  1  reset pulse to the step unit
oStepEnable  out  1  enable to the step unit
oStepAlpha  out  32  registered alpha_m
oStepError  out  32  registered E_m
iStepDone  in  1  step unit done; sticky until the step unit is reset
iStepK  in  32  K_{m+1}
iStepError  in  32  E_{m+1}
oKValid  out  1  one-cycle strobe: oK/oKIdx are valid
oKIdx  out  ORDER_W  m for the emitted K
oK  out  32  K_{m+1}
oError  out  32  final prediction error, valid with oDone
oBusy  out  1  high from the cycle after iStart until oDone
oDone  out  1  one-cycle strobe at frame end
oFault  out  2  00 ok, 01 degenerate error, 10 step timeout; valid with oDone

Behaviour:
- Reset: state IDLE; m=0; all outputs 0. oStepReset is held 1 while iReset is high. Reset mid-frame aborts the frame with no oDone.
- States: IDLE, REQ, STEP_RST, STEP_RUN, EMIT, FILL, FINISH.
- IDLE: on iStart, latch order = min(iOrder, MAX_ORDER) and E = iError0; m <= 0.
  - order == 0 -> FINISH with oFault=00.
  - iError0[30:0] == 0 -> FILL with fault 01.
  - Otherwise -> REQ.
- REQ: oAlphaReq=1, oAlphaIdx=m. On iAlphaValid, latch alpha -> STEP_RST. An iAlphaValid arriving outside REQ is ignored.
- STEP_RST: oStepReset=1 for exactly one cycle; oStepAlpha and oStepError are already stable -> STEP_RUN; timer cleared.
- STEP_RUN: oStepEnable=1; timer increments each cycle.
  - iStepDone=1 -> latch iStepK and iStepError; drop enable -> EMIT.
  - timer reaches STEP_TIMEOUT-1 first -> FILL with fault 10.
  - Done and timeout in the same cycle -> done wins.
- EMIT: oKValid=1 for one cycle with oKIdx=m, oK=latched K; E <= latched error.
  - m == order-1 -> FINISH.
  - New E[30:0] == 0 -> FILL with fault 01.
  - Otherwise m <= m+1 -> REQ.
- FILL: emits oKValid with oK=0 for each remaining index m+1..order-1, one per cycle, so downstream always receives exactly `order` K values -> FINISH.
  - In a timeout abort, FILL starts at the current m, since that K was never emitted.
- FINISH: oDone=1 for one cycle; oError=E; oFault set -> IDLE.
- oBusy=1 in every state except IDLE.
- Latency per order = alpha wait + 1 (STEP_RST) + step latency + 1 (STEP_RUN exit) + 1 (EMIT).
- A second iStart while busy is ignored. iStart in the FINISH cycle is also ignored.
- Index arithmetic is unsigned ORDER_W; m never wraps because the terminal test happens before the increment.
- The sequencer does no float arithmetic; degeneracy is detected by testing bits [30:0] == 0, so both +0 and -0 count.

Decomposition:
- Shared encoder package: state encoding enum, fault codes (FAULT_OK=2'd0, FAULT_DEGEN=2'd1, FAULT_TIMEOUT=2'd2), FP_ZERO_MASK=32'h7FFFFFFF, float constant FP_ONE=32'h3F800000 for benches.
- One sub-module is natural: step_watchdog, a loadable down-counter with an expiry flag. Everything else stays in one FSM module.

Test Plan:
- Bench step model: 31-cycle latency, computing K=-a/E and E'=E-E*K^2.
- order=1, iError0=3F800000, alpha=3F000000 -> one oKValid: oKIdx=0, oK=BF000000; oDone with oError=3F400000, oFault=00.
- order=3, alphas 3F000000/0/0 delivered after 0/5/17-cycle delays:
  - oKIdx sequence 0,1,2 with oK BF000000, 00000000, 00000000.
  - oError=3F400000.
  - oAlphaReq stays high through every delay.
- order=4, iError0=00000000 -> four oKValid with oK=0, no alpha requests, oFault=01.
- Step model never asserts done, order=2 -> after 64 STEP_RUN cycles, two zero K strobes (idx 0,1), oFault=10.
- Assert iReset mid-STEP_RUN, then start a new frame with order=1 -> no oDone from the aborted frame; the new frame completes normally; iStart pulses while busy are ignored.
- iOrder=40 with MAX_ORDER=32 -> exactly 32 oKValid strobes, last oKIdx=31.
